// File: rtl/divseq.sv
// divseq: sequential signed divider, one restoring step per cycle.
// Valid/ready on both sides; results are held until taken.
module divseq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quot,
  output logic [N-1:0] rem,
  output logic         divzero
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_prem;
  logic [N-1:0]  r_dvd;
  logic [N:0]    r_dvs;
  logic [N-1:0]  r_a;
  logic          r_sa;
  logic          r_sq;
  logic          r_dz;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [N-1:0]  r_quot;
  logic [N-1:0]  r_rem;
  logic          r_divzero;

  // Remainder stays below |b| <= 2^(N-1), so N bits plus the
  // incoming dividend bit cover the shifted trial value.
  logic [N:0]    w_shift;
  logic          w_ge;

  assign w_shift = {r_prem, r_dvd[N-1]};
  assign w_ge    = (w_shift >= r_dvs);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_prem      <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_a         <= '0;
      r_sa        <= 1'b0;
      r_sq        <= 1'b0;
      r_dz        <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_divzero   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_dvd      <= a[N-1] ? N'(-a) : a;
            r_dvs      <= b[N-1] ? -{1'b1, b} : {1'b0, b};
            r_a        <= a;
            r_sa       <= a[N-1];
            r_sq       <= a[N-1] ^ b[N-1];
            r_dz       <= (b == '0);
            r_prem     <= '0;
            r_cnt      <= CW'(N - 1);
            r_in_ready <= 1'b0;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_prem <= w_ge ? N'(w_shift - r_dvs) : w_shift[N-1:0];
          r_dvd  <= {r_dvd[N-2:0], w_ge};
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FIX: begin
          if (r_dz) begin
            r_quot <= '1;
            r_rem  <= r_a;
          end else begin
            r_quot <= r_sq ? -r_dvd : r_dvd;
            r_rem  <= r_sa ? -r_prem : r_prem;
          end
          r_divzero   <= r_dz;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign quot      = r_quot;
  assign rem       = r_rem;
  assign divzero   = r_divzero;

endmodule

// File: tb/tb_divseq.sv
// tb_divseq: directed and random divisions against an
// integer-arithmetic reference model.
module tb_divseq;

  logic       clk = 1'b0;
  logic       nreset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quot;
  logic [7:0] rem;
  logic       divzero;

  int checks = 0;
  int failures = 0;

  divseq #(.N(8)) dut (
    .clk(clk),
    .nreset(nreset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quot(quot),
    .rem(rem),
    .divzero(divzero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference: C-style truncating division on plain integers.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic dz);
    int ia;
    int ib;
    ia = int'($signed(ma));
    ib = int'($signed(mb));
    if (ib == 0) begin
      q = 8'hFF;
      r = ma;
      dz = 1'b1;
    end else begin
      q = 8'(ia / ib);
      r = 8'(ia % ib);
      dz = 1'b0;
    end
  endtask

  // Inputs driven and outputs sampled on the falling edge.
  task automatic run_div(input logic [7:0] ta, input logic [7:0] tb_,
                         input int hold, input bit toggle,
                         input string tag);
    logic [7:0] eq;
    logic [7:0] er;
    logic       ed;
    int lat;
    model(ta, tb_, eq, er, ed);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = ta;
    b = tb_;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (toggle && !out_valid) begin
        in_valid = lat[0];
        a = 8'($urandom);
        b = 8'($urandom);
      end
    end
    in_valid = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'd9);
    check({tag, "_quot"}, 32'(quot), 32'(eq));
    check({tag, "_rem"}, 32'(rem), 32'(er));
    check({tag, "_dz"}, 32'(divzero), 32'(ed));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold"}, {out_valid, in_ready, divzero, quot, rem},
            {1'b1, 1'b0, ed, eq, er});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_handoff"}, {out_valid, in_ready}, {1'b0, 1'b1});
    check({tag, "_kept"}, {divzero, quot, rem}, {ed, eq, er});
  endtask

  initial begin
    nreset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    #12;
    check("rst_out", {quot, rem, divzero, out_valid}, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    run_div(8'd100, 8'd7, 0, 1'b0, "basic");
    run_div(8'(-100), 8'd7, 0, 1'b0, "neg_a");
    run_div(8'd100, 8'(-7), 0, 1'b0, "neg_b");
    run_div(8'(-100), 8'(-7), 0, 1'b0, "neg_ab");
    run_div(8'h80, 8'hFF, 0, 1'b0, "min_m1");
    run_div(8'h80, 8'd1, 0, 1'b0, "min_p1");
    run_div(8'd127, 8'h80, 0, 1'b0, "max_min");
    run_div(8'd5, 8'd0, 0, 1'b0, "divzero");
    run_div(8'd9, 8'd3, 0, 1'b0, "after_dz");
    run_div(8'd77, 8'(-9), 20, 1'b1, "backpress");

    for (int k = 0; k < 40; k++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_div(ra, rb, int'($urandom_range(0, 2)), 1'b0, "rand");
    end

    // Abort in the fourth CALC cycle.
    a = 8'd33;
    b = 8'd4;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    nreset = 1'b0;
    #1;
    check("midrst_out", {quot, rem, divzero, out_valid}, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    run_div(8'd50, 8'd5, 0, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
